uart_ctrl: RTL and testbench

// Controller for the peripheral UART at 0x40000018..0x40000020 (TXD/RXD/CON).

---
 rtl/uart_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-mapped 8N1 UART (TXD/RXD/CON) sequenced from a 16x-oversample baud tick.
// rdata is combinational and irq is registered one clk after a flag change; TXD writes while busy are dropped.
module uart_ctrl #(
  parameter logic [31:0] ADDR_TXD = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON = 32'h4000_0020,
  parameter int          OVS      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        baud_tick,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);
  localparam int            CW       = $clog2(OVS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic unused_wdata;

  assign sel_txd      = (addr == ADDR_TXD);
  assign sel_rxd      = (addr == ADDR_RXD);
  assign sel_con      = (addr == ADDR_CON);
  assign wr_txd       = wr & sel_txd;
  assign wr_con       = wr & sel_con;
  assign rd_rxd       = rd & sel_rxd;
  assign rd_con       = rd & sel_con;
  assign unused_wdata = ^wdata[31:8];

  // ---------------- transmitter ----------------
  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_dat_q, tx_dat_d;
  logic          txd_q, txd_d;
  logic          tx_last, tx_done_set, tx_busy;

  assign tx_last = baud_tick && (tx_cnt_q == CNT_LAST);
  assign tx_busy = (tx_state_q != S_IDLE);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_dat_d    = tx_dat_q;
    txd_d       = txd_q;
    tx_done_set = 1'b0;
    if (tx_busy && baud_tick) begin
      tx_cnt_d = tx_last ? '0 : tx_cnt_q + CW'(1);
    end
    case (tx_state_q)
      S_IDLE: begin
        if (wr_txd) begin
          tx_dat_d   = wdata[7:0];
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_last) begin
          tx_bit_d   = 3'd0;
          txd_d      = tx_dat_q[0];
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_last) begin
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_dat_q[tx_bit_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (tx_last) begin
          tx_done_set = 1'b1;
          tx_state_d  = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_dat_q   <= 8'd0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_dat_q   <= tx_dat_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------- receiver ----------------
  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_dat_q, rx_dat_d;
  logic          rx_rdy_set;

  always_comb begin
    rx_s1_d    = rxd;
    rx_s2_d    = rx_s1_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_dat_d   = rx_dat_q;
    rx_rdy_set = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (rx_cnt_q == CNT_MID) begin
            rx_cnt_d   = '0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = S_IDLE;
            if (rx_s2_q) begin
              rx_dat_d   = rx_sh_q;
              rx_rdy_set = 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      rx_dat_q   <= 8'd0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_dat_q   <= rx_dat_d;
    end
  end

  // ---------------- control/status and interrupt ----------------
  // Flag sets are ORed in after the read-clear so a coincident set survives.
  logic [1:0] en_q, en_d;
  logic       done_q, done_d, rdy_q, rdy_d, irq_q, irq_d;
  logic [4:0] con_val;

  always_comb begin
    en_d   = wr_con ? wdata[1:0] : en_q;
    done_d = tx_done_set | (done_q & ~rd_con);
    rdy_d  = rx_rdy_set | (rdy_q & ~rd_rxd);
    irq_d  = (en_q[0] & done_q) | (en_q[1] & rdy_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q   <= 2'b00;
      done_q <= 1'b0;
      rdy_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      done_q <= done_d;
      rdy_q  <= rdy_d;
      irq_q  <= irq_d;
    end
  end

  assign con_val = {tx_busy, rdy_q, done_q, en_q};

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      if (sel_txd)      rdata = {24'd0, tx_dat_q};
      else if (sel_rxd) rdata = {24'd0, rx_dat_q};
      else if (sel_con) rdata = {27'd0, con_val};
    end
  end

  assign txd = txd_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: behavioural frame/flag model plus directed literal checks.
module tb_uart_ctrl;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam int          TDIV  = 4;
  localparam int          FRAME = 160;

  logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0;
  logic        baud_tick = 1'b0, rxd = 1'b1;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        txd, irq;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_div = 0;

  uart_ctrl dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .baud_tick(baud_tick), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (tick_div == 0);
      tick_div  = (tick_div + 1) % TDIV;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_txd, m_rxd;
  logic [1:0] m_en;
  logic       m_done, m_rdy, m_irq, m_tx_act, m_was_act;
  int         m_tx_ticks, m_skip;
  int         rx_req_cnt = 0, rx_seen = 0;
  logic [7:0] rx_req_byte = 8'd0;
  logic       rx_req_ok = 1'b0, rx_pend = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_txd = 8'd0; m_rxd = 8'd0; m_en = 2'b00;
      m_done = 1'b0; m_rdy = 1'b0; m_irq = 1'b0; m_tx_act = 1'b0;
      m_tx_ticks = 0; m_skip = 0; rx_seen = rx_req_cnt;
    end else begin
      m_irq     = (m_en[0] & m_done) | (m_en[1] & m_rdy);
      m_was_act = m_tx_act;
      if (rd && addr == A_CON) m_done = 1'b0;
      if (rd && addr == A_RXD) m_rdy = 1'b0;
      if (wr && addr == A_CON) m_en = wdata[1:0];
      if (m_was_act) begin
        if (baud_tick) begin
          m_tx_ticks++;
          if (m_tx_ticks == FRAME) begin
            m_tx_act = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (wr && addr == A_TXD) begin
        m_txd      = wdata[7:0];
        m_tx_act   = 1'b1;
        m_tx_ticks = 0;
      end
      if (m_skip > 0) m_skip--;
      if (rx_seen != rx_req_cnt) begin
        rx_seen = rx_req_cnt;
        if (rx_req_ok) begin
          m_rxd = rx_req_byte;
          m_rdy = 1'b1;
        end
        m_skip = 1;
      end
    end
  end

  function automatic logic unsettled();
    return rx_pend || (rx_seen != rx_req_cnt) || (m_skip > 0);
  endfunction

  // Frame slot k = ticks/16: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic exp_txd();
    int idx;
    if (!m_tx_act) return 1'b1;
    idx = m_tx_ticks / 16;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_txd[idx-1];
  endfunction

  logic [31:0] con_mask, exp_con;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
    end else begin
      check("txd", {31'd0, txd}, {31'd0, exp_txd()});
      if (!unsettled()) check("irq", {31'd0, irq}, {31'd0, m_irq});
      if (rd && addr == A_CON) begin
        con_mask = unsettled() ? 32'hFFFF_FFF7 : 32'hFFFF_FFFF;
        exp_con  = {27'd0, m_tx_act, m_rdy, m_done, m_en};
        check("rdata_con", rdata & con_mask, exp_con & con_mask);
      end else if (rd && addr == A_TXD) begin
        check("rdata_txd", rdata, {24'd0, m_txd});
      end else if (rd && addr == A_RXD) begin
        if (!unsettled()) check("rdata_rxd", rdata, {24'd0, m_rxd});
      end else begin
        check("rdata_idle", rdata, 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0; wdata = $urandom; addr = $urandom;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    @(negedge clk);
    d = rdata;
    @(posedge clk);
    #1;
    rd = 1'b0; addr = $urandom;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_ticks(16);
    end
    rx_pend = 1'b1;
    rxd = stop_ok;
    if (stop_ok) begin
      wait_ticks(16);
    end else begin
      // Bad stop bit is held only past its sampling point so the trailing low is rejected as a glitch.
      wait_ticks(10);
      rxd = 1'b1;
      wait_ticks(6);
    end
    rx_req_byte = b;
    rx_req_ok   = stop_ok;
    rx_req_cnt++;
    rx_pend = 1'b0;
    wait_ticks(12);
  endtask

  task automatic glitch();
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(4);
    rxd = 1'b1;
    wait_ticks(24);
  endtask

  task automatic capture_tx(output logic [9:0] cap);
    wait_ticks(8);
    cap[0] = txd;
    for (int k = 1; k < 10; k++) begin
      wait_ticks(16);
      cap[k] = txd;
    end
    wait_ticks(8);
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (m_tx_act && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  logic [31:0] rv, rv2;
  logic [9:0]  cap;
  int          kind;

  initial begin
    // 1. reset state
    rd = 1'b1; addr = A_CON;
    repeat (3) @(posedge clk);
    #1;
    check("t1_txd", {31'd0, txd}, 32'd1);
    check("t1_irq", {31'd0, irq}, 32'd0);
    check("t1_rdata", rdata, 32'd0);
    rd = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus_read(A_CON, rv);
    check("t1_con", rv, 32'd0);

    // 2. transmit 0xA5
    bus_write(A_TXD, 32'hA5);
    fork
      capture_tx(cap);
      begin
        wait_ticks(40);
        bus_read(A_CON, rv2);
      end
    join
    check("t2_busy", {31'd0, rv2[4]}, 32'd1);
    check("t2_frame", {22'd0, cap}, 32'h34A);
    bus_read(A_CON, rv);
    check("t2_con_done", rv, 32'h04);

    // 3. receive 0x3C with rx irq enabled
    bus_write(A_CON, 32'h02);
    send_frame(8'h3C, 1'b1);
    check("t3_irq_set", {31'd0, irq}, 32'd1);
    bus_read(A_CON, rv);
    check("t3_con", rv, 32'h0A);
    bus_read(A_RXD, rv);
    check("t3_rxd", rv, 32'h3C);
    @(posedge clk);
    #1;
    check("t3_irq_clr", {31'd0, irq}, 32'd0);

    // 4. second TXD write during a frame is dropped
    bus_write(A_TXD, 32'h11);
    wait_ticks(50);
    bus_write(A_TXD, 32'h22);
    bus_read(A_TXD, rv);
    check("t4_txd_reg", rv, 32'h11);
    wait_tx_idle();
    bus_read(A_CON, rv);
    check("t4_con", rv, 32'h06);

    // 5. glitch and bad stop bit leave RXD alone
    glitch();
    bus_read(A_CON, rv);
    check("t5_glitch_con", rv, 32'h02);
    send_frame(8'h55, 1'b0);
    bus_read(A_RXD, rv);
    check("t5_badstop_rxd", rv, 32'h3C);
    bus_read(A_CON, rv);
    check("t5_badstop_con", rv, 32'h02);

    // 6. reset in the middle of data bit 3
    bus_write(A_CON, 32'h03);
    bus_write(A_TXD, 32'h52);
    wait_ticks(72);
    check("t6_pre_txd", {31'd0, txd}, 32'd0);
    reset = 1'b0;
    #1;
    check("t6_txd", {31'd0, txd}, 32'd1);
    check("t6_irq", {31'd0, irq}, 32'd0);
    rd = 1'b1; addr = A_CON;
    #1;
    check("t6_rdata", rdata, 32'd0);
    rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus_read(A_CON, rv);
    check("t6_con", rv, 32'd0);
    bus_write(A_TXD, 32'h01);
    capture_tx(cap);
    check("t6_frame", {22'd0, cap}, 32'h202);

    // Randomized concurrent RX traffic and bus activity against the model
    for (int it = 0; it < 10; it++) begin
      fork
        begin
          kind = $urandom_range(0, 5);
          if (kind == 0) glitch();
          else send_frame(8'($urandom), kind != 1);
        end
        begin
          for (int j = 0; j < 12; j++) begin
            repeat ($urandom_range(1, 40)) @(posedge clk);
            #1;
            case ($urandom_range(0, 4))
              0: bus_write(A_TXD, $urandom);
              1: bus_write(A_CON, $urandom);
              2: bus_read(A_CON, rv);
              3: bus_read(A_TXD, rv);
              default: if (!rx_pend && rx_seen == rx_req_cnt) bus_read(A_RXD, rv);
            endcase
          end
        end
      join
    end
    wait_tx_idle();
    bus_read(A_CON, rv);
    check("end_not_busy", {31'd0, rv[4]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
